// File: rtl/pingpong_pkg.sv
// Shared defaults and sizing helper for the N-bank ping-pong buffer.
// Imported by the buffer top level and its bank RAM.
package pingpong_pkg;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_DEPTH     = 64;
   localparam int DEF_NUM_BANKS = 2;

   // Ceiling log2 with a floor of 1 so single-bit fields never collapse to zero width.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/pp_sdp_ram.sv
// Simple dual-port bank RAM: one write port, one read port with a registered output.
// The array itself is never reset; only the read register clears.
module pp_sdp_ram
   import pingpong_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      we,
   input  logic [clog2(DEPTH)-1:0]   waddr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic                      re,
   input  logic [clog2(DEPTH)-1:0]   raddr,
   output logic [DATA_W-1:0]         rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Output register holds its value when no read is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/pingpong_nbank_buffer.sv
// N-bank ping-pong buffer: the producer fills and commits banks in ring order,
// the consumer reads and releases them in the same order.
module pingpong_nbank_buffer
   import pingpong_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int NUM_BANKS = DEF_NUM_BANKS
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_en,
   input  logic [clog2(DEPTH)-1:0]        wr_addr,
   input  logic [DATA_W-1:0]              wr_data,
   input  logic                           wr_commit,
   output logic                           wr_ready,
   input  logic                           rd_en,
   input  logic [clog2(DEPTH)-1:0]        rd_addr,
   output logic [DATA_W-1:0]              rd_data,
   input  logic                           rd_release,
   output logic                           rd_ready,
   output logic [NUM_BANKS-1:0]           bank_busy,
   output logic [clog2(NUM_BANKS+1)-1:0]  full_cnt,
   output logic                           err_ovf,
   output logic                           err_udf
);

   localparam int PW = clog2(NUM_BANKS);
   localparam int CW = clog2(NUM_BANKS + 1);
   localparam logic [PW-1:0] LAST_BANK = PW'(NUM_BANKS - 1);
   localparam logic [CW-1:0] ALL_FULL  = CW'(NUM_BANKS);

   logic [PW-1:0]     wp;
   logic [PW-1:0]     rp;
   logic [PW-1:0]     rd_sel;
   logic              wr_fire;
   logic              commit_fire;
   logic              rd_fire;
   logic              release_fire;
   logic [DATA_W-1:0] bank_dout [NUM_BANKS];

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_BANK) ? '0 : p + 1'b1;
   endfunction

   // Handshake: wr_ready/rd_ready come only from registered state. A wr_en or
   // wr_commit takes effect only while wr_ready=1, an rd_en or rd_release only
   // while rd_ready=1; any request outside that is dropped and flags an error.
   assign wr_ready     = (full_cnt < ALL_FULL);
   assign rd_ready     = (full_cnt != '0);
   assign wr_fire      = wr_en      && wr_ready;
   assign commit_fire  = wr_commit  && wr_ready;
   assign rd_fire      = rd_en      && rd_ready;
   assign release_fire = rd_release && rd_ready;

   // wp==rp only when all banks are empty or all are full, so a legal commit and
   // a legal release never touch the same bank_busy bit in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp        <= '0;
         rp        <= '0;
         rd_sel    <= '0;
         full_cnt  <= '0;
         bank_busy <= '0;
         err_ovf   <= 1'b0;
         err_udf   <= 1'b0;
      end else begin
         if (commit_fire) begin
            bank_busy[wp] <= 1'b1;
            wp            <= next_ptr(wp);
         end
         if (release_fire) begin
            bank_busy[rp] <= 1'b0;
            rp            <= next_ptr(rp);
         end
         if (commit_fire && !release_fire) begin
            full_cnt <= full_cnt + 1'b1;
         end else if (!commit_fire && release_fire) begin
            full_cnt <= full_cnt - 1'b1;
         end
         if (rd_fire) begin
            rd_sel <= rp;
         end
         if ((wr_en || wr_commit) && !wr_ready) begin
            err_ovf <= 1'b1;
         end
         if ((rd_en || rd_release) && !rd_ready) begin
            err_udf <= 1'b1;
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      pp_sdp_ram #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_ram (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (wr_fire && (wp == PW'(b))),
         .waddr (wr_addr),
         .wdata (wr_data),
         .re    (rd_fire && (rp == PW'(b))),
         .raddr (rd_addr),
         .rdata (bank_dout[b])
      );
   end

   // rd_sel remembers which bank the last accepted read targeted.
   assign rd_data = bank_dout[rd_sel];

endmodule

// File: tb/tb_pingpong_nbank_buffer.sv
// Bench for pingpong_nbank_buffer: a 4-bank/64-word instance for directed corner
// cases and a 3-bank/4-word instance for continuous streaming.
module tb_pingpong_nbank_buffer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic a_rst_n = 1'b0;
   logic b_rst_n = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- instance A: 4 banks x 64 words x 32 bits ----------------
   logic        a_wr_en = 0, a_wr_commit = 0, a_rd_en = 0, a_rd_release = 0;
   logic [5:0]  a_wr_addr = '0, a_rd_addr = '0;
   logic [31:0] a_wr_data = '0;
   logic        a_wr_ready, a_rd_ready, a_err_ovf, a_err_udf;
   logic [31:0] a_rd_data;
   logic [3:0]  a_bank_busy;
   logic [2:0]  a_full_cnt;

   pingpong_nbank_buffer #(.DATA_W(32), .DEPTH(64), .NUM_BANKS(4)) dut_a (
      .clk        (clk),
      .rst_n      (a_rst_n),
      .wr_en      (a_wr_en),
      .wr_addr    (a_wr_addr),
      .wr_data    (a_wr_data),
      .wr_commit  (a_wr_commit),
      .wr_ready   (a_wr_ready),
      .rd_en      (a_rd_en),
      .rd_addr    (a_rd_addr),
      .rd_data    (a_rd_data),
      .rd_release (a_rd_release),
      .rd_ready   (a_rd_ready),
      .bank_busy  (a_bank_busy),
      .full_cnt   (a_full_cnt),
      .err_ovf    (a_err_ovf),
      .err_udf    (a_err_udf)
   );

   // ---------------- instance B: 3 banks x 4 words x 16 bits ----------------
   logic        b_wr_en = 0, b_wr_commit = 0, b_rd_en = 0, b_rd_release = 0;
   logic [1:0]  b_wr_addr = '0, b_rd_addr = '0;
   logic [15:0] b_wr_data = '0;
   logic        b_wr_ready, b_rd_ready, b_err_ovf, b_err_udf;
   logic [15:0] b_rd_data;
   logic [2:0]  b_bank_busy;
   logic [1:0]  b_full_cnt;

   pingpong_nbank_buffer #(.DATA_W(16), .DEPTH(4), .NUM_BANKS(3)) dut_b (
      .clk        (clk),
      .rst_n      (b_rst_n),
      .wr_en      (b_wr_en),
      .wr_addr    (b_wr_addr),
      .wr_data    (b_wr_data),
      .wr_commit  (b_wr_commit),
      .wr_ready   (b_wr_ready),
      .rd_en      (b_rd_en),
      .rd_addr    (b_rd_addr),
      .rd_data    (b_rd_data),
      .rd_release (b_rd_release),
      .rd_ready   (b_rd_ready),
      .bank_busy  (b_bank_busy),
      .full_cnt   (b_full_cnt),
      .err_ovf    (b_err_ovf),
      .err_udf    (b_err_udf)
   );

   // ---------------- scoreboard ----------------
   logic [31:0] a_exp_q[$];
   logic [15:0] b_exp_q[$];
   logic a_rd_exp = 1'b0, b_rd_exp = 1'b0;
   logic a_vld = 1'b0, b_vld = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected read data appears one cycle after an accepted rd_en.
   always @(posedge clk) begin
      a_vld <= a_rd_exp;
      b_vld <= b_rd_exp;
   end

   always @(negedge clk) begin
      if (a_vld) begin
         if (a_exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL a_rd_data: got 0x%0h with no expected entry", a_rd_data);
         end else begin
            check("a_rd_data", a_rd_data, a_exp_q.pop_front());
         end
      end
      if (b_vld) begin
         if (b_exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL b_rd_data: got 0x%0h with no expected entry", b_rd_data);
         end else begin
            check("b_rd_data", 32'(b_rd_data), 32'(b_exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic a_step(input logic en, input logic [5:0] wa, input logic [31:0] wd,
                         input logic cm, input logic re, input logic [5:0] ra,
                         input logic rel, input logic exp_rd, input logic [31:0] exp_val);
      a_wr_en = en; a_wr_addr = wa; a_wr_data = wd; a_wr_commit = cm;
      a_rd_en = re; a_rd_addr = ra; a_rd_release = rel; a_rd_exp = exp_rd;
      if (exp_rd) a_exp_q.push_back(exp_val);
      @(posedge clk);
      #1;
      a_wr_en = 0; a_wr_commit = 0; a_rd_en = 0; a_rd_release = 0; a_rd_exp = 0;
   endtask

   task automatic b_step(input logic en, input logic [1:0] wa, input logic [15:0] wd,
                         input logic cm, input logic re, input logic [1:0] ra,
                         input logic rel, input logic exp_rd, input logic [15:0] exp_val);
      b_wr_en = en; b_wr_addr = wa; b_wr_data = wd; b_wr_commit = cm;
      b_rd_en = re; b_rd_addr = ra; b_rd_release = rel; b_rd_exp = exp_rd;
      if (exp_rd) b_exp_q.push_back(exp_val);
      @(posedge clk);
      #1;
      b_wr_en = 0; b_wr_commit = 0; b_rd_en = 0; b_rd_release = 0; b_rd_exp = 0;
   endtask

   task automatic a_reset_values(input string tag);
      check({tag, "_full_cnt"},  32'(a_full_cnt),  32'd0);
      check({tag, "_bank_busy"}, 32'(a_bank_busy), 32'd0);
      check({tag, "_wr_ready"},  32'(a_wr_ready),  32'd1);
      check({tag, "_rd_ready"},  32'(a_rd_ready),  32'd0);
      check({tag, "_rd_data"},   a_rd_data,        32'd0);
      check({tag, "_err_ovf"},   32'(a_err_ovf),   32'd0);
      check({tag, "_err_udf"},   32'(a_err_udf),   32'd0);
      check({tag, "_wp"},        32'(dut_a.wp),    32'd0);
      check({tag, "_rp"},        32'(dut_a.rp),    32'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      repeat (2) @(posedge clk);
      #1;
      a_reset_values("rst_a");
      check("rst_b_wr_ready", 32'(b_wr_ready), 32'd1);
      check("rst_b_rd_ready", 32'(b_rd_ready), 32'd0);
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill bank 0 with word == address, commit, then read back.
      for (int i = 0; i < 64; i++) a_step(1, 6'(i), 32'(i), 0, 0, '0, 0, 0, '0);
      check("a_pre_commit_rd_ready", 32'(a_rd_ready), 32'd0);
      a_step(0, '0, '0, 1, 0, '0, 0, 0, '0);
      check("a_c1_full_cnt",  32'(a_full_cnt),  32'd1);
      check("a_c1_rd_ready",  32'(a_rd_ready),  32'd1);
      check("a_c1_bank_busy", 32'(a_bank_busy), 32'b0001);
      check("a_c1_wp",        32'(dut_a.wp),    32'd1);
      a_step(0, '0, '0, 0, 1, 6'd5,  0, 1, 32'd5);
      a_step(0, '0, '0, 0, 1, 6'd63, 0, 1, 32'd63);

      // Bank 1: last write + commit + release + read of old bank 0 in one cycle.
      for (int i = 0; i < 3; i++) a_step(1, 6'(i), 32'(100 + i), 0, 0, '0, 0, 0, '0);
      a_step(1, 6'd3, 32'd103, 1, 1, 6'd5, 1, 1, 32'd5);
      check("a_swap_full_cnt",  32'(a_full_cnt),  32'd1);
      check("a_swap_wp",        32'(dut_a.wp),    32'd2);
      check("a_swap_rp",        32'(dut_a.rp),    32'd1);
      check("a_swap_bank_busy", 32'(a_bank_busy), 32'b0010);

      // Uncommitted write to bank 2 must not disturb reads of bank 1.
      a_step(1, 6'd0, 32'hDEAD, 0, 1, 6'd0, 0, 1, 32'd100);
      a_step(0, '0, '0, 0, 1, 6'd3, 0, 1, 32'd103);

      // Fill the ring.
      repeat (3) a_step(0, '0, '0, 1, 0, '0, 0, 0, '0);
      check("a_full_full_cnt",  32'(a_full_cnt),  32'd4);
      check("a_full_wr_ready",  32'(a_wr_ready),  32'd0);
      check("a_full_bank_busy", 32'(a_bank_busy), 32'b1111);
      check("a_full_err_ovf",   32'(a_err_ovf),   32'd0);
      a_step(0, '0, '0, 1, 0, '0, 0, 0, '0);
      check("a_ovf_err_ovf",  32'(a_err_ovf),  32'd1);
      check("a_ovf_full_cnt", 32'(a_full_cnt), 32'd4);
      check("a_ovf_wp",       32'(dut_a.wp),   32'd1);
      a_step(1, 6'd0, 32'h0BAD, 0, 1, 6'd0, 0, 1, 32'd100);

      // Drain two banks; bank 2 now holds the earlier uncommitted word.
      a_step(0, '0, '0, 0, 0, '0, 1, 0, '0);
      a_step(0, '0, '0, 0, 1, 6'd0, 0, 1, 32'hDEAD);
      a_step(0, '0, '0, 0, 0, '0, 1, 0, '0);
      check("a_drain_full_cnt", 32'(a_full_cnt), 32'd2);
      check("a_drain_rp",       32'(dut_a.rp),   32'd3);
      check("a_drain_err_ovf",  32'(a_err_ovf),  32'd1);

      // Asynchronous reset between clock edges.
      #2;
      a_rst_n = 1'b0;
      #1;
      a_reset_values("async_a");
      @(posedge clk);
      #1;
      a_rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Underflow from empty.
      a_step(0, '0, '0, 0, 0, '0, 1, 0, '0);
      check("a_udf_err_udf",  32'(a_err_udf),  32'd1);
      check("a_udf_rp",       32'(dut_a.rp),   32'd0);
      check("a_udf_full_cnt", 32'(a_full_cnt), 32'd0);
      a_step(0, '0, '0, 0, 1, 6'd5, 0, 0, '0);
      check("a_udf_rd_data",  a_rd_data,       32'd0);
      check("a_udf_err_ovf",  32'(a_err_ovf),  32'd0);

      // Streaming on 3 banks: 30 banks written and read back in commit order.
      for (int k = 0; k <= 30; k++) begin
         for (int i = 0; i < 4; i++) begin
            logic do_w, do_r;
            do_w = (k < 30);
            do_r = (k >= 1);
            b_step(do_w, 2'(i), 16'(32'hA500 ^ (k * 4 + i)), do_w && (i == 3),
                   do_r, 2'(i), do_r && (i == 3), do_r, 16'(32'hA500 ^ ((k - 1) * 4 + i)));
         end
         if (k == 0) begin
            check("b_first_full_cnt", 32'(b_full_cnt), 32'd1);
         end
      end
      check("b_end_full_cnt", 32'(b_full_cnt), 32'd0);
      check("b_end_err_ovf",  32'(b_err_ovf),  32'd0);
      check("b_end_err_udf",  32'(b_err_udf),  32'd0);
      check("b_end_wp",       32'(dut_b.wp),   32'd0);
      check("b_end_rp",       32'(dut_b.rp),   32'd0);

      repeat (2) @(posedge clk);
      #1;
      check("a_queue_drained", 32'(a_exp_q.size()), 32'd0);
      check("b_queue_drained", 32'(b_exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pingpong_nbank_buffer.md
PINGPONG_NBANK_BUFFER -- requirements
Module: pingpong_nbank_buffer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_W SHALL default to 32 and set the data word width in bits.
REQ-003 Parameter DEPTH SHALL default to 64 and set the words per bank; it SHALL be a power of two, minimum 2.
REQ-004 Parameter NUM_BANKS SHALL default to 2 and set the number of banks; legal range is 2..8.
REQ-005 Port clk, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port wr_en, input, 1 bit: write the word on wr_data to the current write bank.
REQ-008 Port wr_addr, input, clog2(DEPTH) bits: word address within the write bank.
REQ-009 Port wr_data, input, DATA_W bits: write data.
REQ-010 Port wr_commit, input, 1 bit: mark the current write bank full and advance the write pointer.
REQ-011 Port wr_ready, output, 1 bit: at least one bank is free.
REQ-012 Port rd_en, input, 1 bit: read from the current read bank.
REQ-013 Port rd_addr, input, clog2(DEPTH) bits: word address within the read bank.
REQ-014 Port rd_data, output, DATA_W bits: registered read data.
REQ-015 Port rd_release, input, 1 bit: free the current read bank and advance the read pointer.
REQ-016 Port rd_ready, output, 1 bit: at least one bank is full.
REQ-017 Port bank_busy, output, NUM_BANKS bits: per-bank full flag.
REQ-018 Port full_cnt, output, clog2(NUM_BANKS+1) bits: number of full banks.
REQ-019 Ports err_ovf and err_udf, outputs, 1 bit each: sticky error flags.

Function
REQ-020 Pointers wp and rp SHALL wrap from NUM_BANKS-1 to 0.
REQ-021 Write and read bank selection SHALL be wp and rp respectively.
REQ-022 wr_ready SHALL equal (full_cnt < NUM_BANKS); rd_ready SHALL equal (full_cnt > 0); both are combinational from registered state.
REQ-023 A wr_en with wr_ready=1 SHALL store wr_data at wr_addr of bank wp.
REQ-024 A wr_en with wr_ready=0 SHALL be dropped and SHALL set err_ovf.
REQ-025 A wr_commit with wr_ready=1 SHALL set bank_busy[wp], advance wp and increment full_cnt.
REQ-026 A wr_commit with wr_ready=0 SHALL be ignored and SHALL set err_ovf.
REQ-027 A wr_en and wr_commit in the same cycle SHALL write to the old bank wp before the advance.
REQ-028 An rd_en with rd_ready=1 SHALL present word rd_addr of bank rp on rd_data exactly 1 cycle later.
REQ-029 An rd_en with rd_ready=0 SHALL leave rd_data unchanged and SHALL set err_udf.
REQ-030 An rd_release with rd_ready=1 SHALL clear bank_busy[rp], advance rp and decrement full_cnt.
REQ-031 An rd_release with rd_ready=0 SHALL be ignored and SHALL set err_udf.
REQ-032 An rd_en and rd_release in the same cycle SHALL read the old bank rp.
REQ-033 A legal wr_commit and a legal rd_release in the same cycle SHALL both take effect, and full_cnt SHALL be unchanged.
REQ-034 A write to a bank SHALL never be visible to a read until that bank has been committed.
REQ-035 err_ovf and err_udf SHALL clear only on reset.

Reset
REQ-036 While rst_n=0: wp, rp, full_cnt, bank_busy, rd_data, err_ovf and err_udf SHALL be 0, wr_ready SHALL be 1 and rd_ready SHALL be 0.
REQ-037 Memory contents SHALL not be reset; reset mid-transfer SHALL discard all bank state.

Structure
REQ-038 Package pingpong_pkg SHALL hold the default DATA_W, DEPTH and NUM_BANKS values and the clog2 helper function.
REQ-039 Bank storage SHALL be one sub-module, pp_sdp_ram (simple dual-port, registered read), instantiated NUM_BANKS times or once with DEPTH*NUM_BANKS words addressed as {bank, addr}.
REQ-040 Pointer and count control SHALL be a single always block in the top level.

Verification
REQ-041 Fill bank 0 (DEPTH=64, words 0..63 = addr), commit, then read addr 5 -> rd_data=5 one cycle after rd_en; rd_ready=1, full_cnt=1.
REQ-042 With NUM_BANKS=4, commit 4 times with no release -> wr_ready=0, full_cnt=4; a 5th commit -> err_ovf=1, full_cnt stays 4.
REQ-043 From empty, rd_release -> err_udf=1, rp=0, full_cnt=0.
REQ-044 full_cnt=1, then wr_commit and rd_release in the same cycle -> full_cnt=1, wp and rp each advance by 1.
REQ-045 Pulse rst_n low with full_cnt=2 -> all outputs return to their reset values asynchronously, before the next clk edge.
REQ-046 Run NUM_BANKS=3 continuous streaming over 10 wraps with a scoreboard -> data read back in commit order and no error flag set.
